// File: rtl/dmem_mmio.sv
// Data-side memory responder: word RAM plus an MMIO page with output FIFO, status and cycle counter.
// Define DMEM_TIMER_EN to build the free-running cycle counter; otherwise CYCLE reads 0.
`timescale 1ns/1ps
module dmem_mmio #(
    parameter int unsigned WORDS      = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    output logic [31:0] rdata,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow
);
    localparam int unsigned AW = $clog2(WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [5:0] OFF_OUT    = 6'h00;
    localparam logic [5:0] OFF_STATUS = 6'h01;
    localparam logic [5:0] OFF_CYCLE  = 6'h02;

    logic          is_mmio;
    logic [5:0]    off;
    logic [AW-1:0] ram_idx;
    logic          unused_addr_lsb;

    // Byte lanes are not supported, so the two LSBs never take part in decode.
    assign is_mmio         = (addr[31:8] == 24'hFFFFFF);
    assign off             = addr[7:2];
    assign ram_idx         = addr[AW+1:2];
    assign unused_addr_lsb = ^addr[1:0];

    logic [31:0] ram_q [WORDS];

    always_ff @(posedge clk) begin
        if (mem_write && !is_mmio) begin
            ram_q[ram_idx] <= wdata;
        end
    end

    logic [31:0]   fifo_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full, empty, pop, push_req, push_ok, drop, clr_ovf;

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign pop      = !empty && out_ready;
    assign push_req = mem_write && is_mmio && (off == OFF_OUT);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign clr_ovf  = mem_write && is_mmio && (off == OFF_STATUS) && wdata[2];

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CW'(1);
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (push_ok) begin
                fifo_q[wr_ptr_q] <= wdata;
            end
        end
    end

    assign out_data  = fifo_q[rd_ptr_q];
    assign out_valid = !empty;
    assign overflow  = overflow_q;

    logic [31:0] cycle_val;

`ifdef DMEM_TIMER_EN
    logic [31:0] cycle_q, cycle_d;

    // A software write takes precedence over the increment.
    always_comb begin
        cycle_d = cycle_q + 32'd1;
        if (mem_write && is_mmio && (off == OFF_CYCLE)) begin
            cycle_d = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    assign cycle_val = cycle_q;
`else
    assign cycle_val = '0;
`endif

    always_comb begin
        rdata = '0;
        if (!is_mmio) begin
            rdata = ram_q[ram_idx];
        end else begin
            case (off)
                OFF_STATUS: rdata = {29'b0, overflow_q, full, empty};
                OFF_CYCLE:  rdata = cycle_val;
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Randomized scoreboard bench for dmem_mmio against a queue/array reference model.
`timescale 1ns/1ps
module tb_dmem_mmio;
    localparam int unsigned WORDS = 64;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] A_OUT  = 32'hFFFFFF00;
    localparam logic [31:0] A_STAT = 32'hFFFFFF04;
    localparam logic [31:0] A_CYC  = 32'hFFFFFF08;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_write = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] rdata, out_data;
    logic        out_valid, overflow;

    dmem_mmio #(.WORDS(WORDS), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .mem_write(mem_write),
        .rdata(rdata), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] drain_q[$];

    logic [31:0] m_ram[int];
    logic [31:0] m_fifo[$];
    logic        m_ovf = 1'b0;
    logic [31:0] m_cyc = '0;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit is_mmio(logic [31:0] a);
        return (a / 256) == 32'h00FFFFFF;
    endfunction

    function automatic int mmio_off(logic [31:0] a);
        return int'((a % 256) / 4);
    endfunction

    function automatic int ram_word(logic [31:0] a);
        return int'((a / 4) % WORDS);
    endfunction

    // Returns 0 when the load value is undefined (unwritten RAM word).
    function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
        logic f, e;
        v = '0;
        if (is_mmio(a)) begin
            f = (m_fifo.size() == DEPTH);
            e = (m_fifo.size() == 0);
            if (mmio_off(a) == 1) v = {29'b0, m_ovf, f, e};
`ifdef DMEM_TIMER_EN
            if (mmio_off(a) == 2) v = m_cyc;
`endif
            return 1'b1;
        end
        if (m_ram.exists(ram_word(a))) begin
            v = m_ram[ram_word(a)];
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic we, input logic rdy);
        logic [31:0] v;
        bit          pop;
        int          sz;
        addr      = a;
        wdata     = d;
        mem_write = we;
        out_ready = rdy;
        if (model_read(a, v)) exp_q.push_back('{0, v});
        exp_q.push_back('{1, 32'(m_fifo.size() != 0)});
        if (m_fifo.size() != 0) exp_q.push_back('{2, m_fifo[0]});
        exp_q.push_back('{3, 32'(m_ovf)});
        @(posedge clk);
        sz  = m_fifo.size();
        pop = (sz != 0) && rdy;
        if (pop) void'(m_fifo.pop_front());
        if (we && !is_mmio(a)) m_ram[ram_word(a)] = d;
        if (we && is_mmio(a) && mmio_off(a) == 0) begin
            if (sz < int'(DEPTH) || pop) begin
                m_fifo.push_back(d);
                drain_q.push_back(d);
            end else begin
                m_ovf = 1'b1;
            end
        end else if (we && is_mmio(a) && mmio_off(a) == 1 && d[2]) begin
            m_ovf = 1'b0;
        end
        if (we && is_mmio(a) && mmio_off(a) == 2) m_cyc = d;
        else m_cyc = m_cyc + 32'd1;
        #1;
    endtask

    // Monitor: compares queued expectations and every drained word, mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                case (e.kind)
                    0:       check("rdata", rdata, e.val);
                    1:       check("out_valid", 32'(out_valid), e.val);
                    2:       check("out_data", out_data, e.val);
                    default: check("overflow", 32'(overflow), e.val);
                endcase
            end
            if (rst_n && out_valid && out_ready) begin
                if (drain_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL drain: got unexpected word %h, expected none", out_data);
                end else begin
                    check("drain", out_data, drain_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] a;
        // Reset state while held in reset.
        addr = A_STAT;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_status", rdata, 32'h1);
        addr = A_CYC;
        #1;
        check("rst_cycle", rdata, 32'd0);
        #1 rst_n = 1'b1;

        // RAM round trip with aliasing and ignored LSBs.
        step(32'h10, 32'hDEADBEEF, 1'b1, 1'b0);
        step(32'h10, 32'h0, 1'b0, 1'b0);
        step(32'h110, 32'h0, 1'b0, 1'b0);
        step(32'h12, 32'h0, 1'b0, 1'b0);

        // FIFO order with backpressure.
        for (int i = 1; i <= 4; i++) step(A_OUT, 32'(i), 1'b1, 1'b0);
        step(A_STAT, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(A_STAT, 32'h0, 1'b0, 1'b1);
        step(A_STAT, 32'h0, 1'b0, 1'b0);

        // Overflow and clear.
        for (int i = 1; i <= 5; i++) step(A_OUT, 32'(i), 1'b1, 1'b0);
        step(A_STAT, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(A_STAT, 32'h0, 1'b0, 1'b1);
        step(A_STAT, 32'h4, 1'b1, 1'b0);
        step(A_STAT, 32'h0, 1'b0, 1'b0);

        // Full with simultaneous push and pop.
        for (int i = 1; i <= 4; i++) step(A_OUT, 32'(i), 1'b1, 1'b0);
        step(A_OUT, 32'd9, 1'b1, 1'b1);
        step(A_STAT, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(A_STAT, 32'h0, 1'b0, 1'b1);

        // Counter load and wrap.
        step(A_CYC, 32'hFFFFFFFE, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(A_CYC, 32'h0, 1'b0, 1'b0);

        // Randomized mix of RAM and MMIO traffic.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 7))
                0, 1, 2: a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3) * WORDS * 4
                                 + $urandom_range(0, 3));
                3, 4:    a = A_OUT + 32'($urandom_range(0, 3));
                5:       a = A_STAT;
                6:       a = A_CYC;
                default: a = ($urandom_range(0, 1) != 0) ? 32'hFFFFFF0C : 32'hFFFFFF80;
            endcase
            step(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
        end

        // Asynchronous reset with 3 entries queued and overflow set.
        for (int i = 0; i < 6; i++) step(A_STAT, 32'h0, 1'b0, 1'b1);
        step(32'h10, 32'h12345678, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) step(A_OUT, 32'(i + 100), 1'b1, 1'b0);
        step(A_CYC, 32'h0, 1'b0, 1'b1);
        step(A_CYC, 32'h0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_overflow", 32'(overflow), 32'd0);
        check("arst_cycle", rdata, 32'd0);
        addr = 32'h10;
        #1;
        check("arst_ram_keep", rdata, 32'h12345678);
        m_fifo.delete();
        drain_q.delete();
        m_ovf = 1'b0;
        m_cyc = '0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(A_CYC, 32'h0, 1'b0, 1'b0);

        // Final drain: every accepted word must have come out.
        for (int i = 1; i <= 3; i++) step(A_OUT, 32'(i + 200), 1'b1, 1'b0);
        for (int i = 0; i < int'(DEPTH) + 1; i++) step(A_STAT, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        check("drain_left", 32'(drain_q.size()), 32'd0);
        void'(model_read(A_STAT, v));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
